// File: rtl/dbgi2c_port_arb.sv
// Debug-I2C port arbiter: filters every candidate SCL/SDA pair, locks the internal
// slave onto the first pair that shows a START, and releases it after STOP+hold or a stuck bus.
module dbgi2c_port_arb #(
  parameter int NPAIR = 5,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rstz,
  input  logic [NPAIR-1:0] i_en,
  input  logic [NPAIR-1:0] i_scl,
  input  logic [NPAIR-1:0] i_sda,
  input  logic             i_slv_sda_oe,
  input  logic [TO_W-1:0]  i_to_lim,
  output logic             o_scl,
  output logic             o_sda,
  output logic [NPAIR-1:0] o_sda_oe,
  output logic [2:0]       o_sel,
  output logic             o_lock,
  output logic             o_conflict
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_HOLD} state_t;

  logic [NPAIR-1:0] scl_s1_q, scl_s2_q, scl_h1_q, scl_h2_q, scl_filt_q, scl_prev_q;
  logic [NPAIR-1:0] sda_s1_q, sda_s2_q, sda_h1_q, sda_h2_q, sda_filt_q, sda_prev_q;
  logic [NPAIR-1:0] start, stop;
  logic [NPAIR-1:0] oe_d, oe_q;
  logic [TO_W-1:0]  cnt_d, cnt_q, cnt_inc;
  logic [2:0]       sel_d, sel_q, first_idx;
  logic             multi_start, act, timeout_hit, locked_d;
  logic             scl_out_d, scl_out_q, sda_out_d, sda_out_q, conflict_d, conflict_q;
  state_t           state_d, state_q;

  // Everything resets to the idle-bus level so no false edge follows reset.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      scl_s1_q   <= '1;
      scl_s2_q   <= '1;
      scl_h1_q   <= '1;
      scl_h2_q   <= '1;
      scl_filt_q <= '1;
      scl_prev_q <= '1;
      sda_s1_q   <= '1;
      sda_s2_q   <= '1;
      sda_h1_q   <= '1;
      sda_h2_q   <= '1;
      sda_filt_q <= '1;
      sda_prev_q <= '1;
    end else begin
      scl_s1_q   <= i_scl;
      scl_s2_q   <= scl_s1_q;
      scl_h1_q   <= scl_s2_q;
      scl_h2_q   <= scl_h1_q;
      scl_filt_q <= (scl_s2_q & scl_h1_q) | (scl_s2_q & scl_h2_q) | (scl_h1_q & scl_h2_q);
      scl_prev_q <= scl_filt_q;
      sda_s1_q   <= i_sda;
      sda_s2_q   <= sda_s1_q;
      sda_h1_q   <= sda_s2_q;
      sda_h2_q   <= sda_h1_q;
      sda_filt_q <= (sda_s2_q & sda_h1_q) | (sda_s2_q & sda_h2_q) | (sda_h1_q & sda_h2_q);
      sda_prev_q <= sda_filt_q;
    end
  end

  assign start = i_en & scl_filt_q & scl_prev_q & sda_prev_q & ~sda_filt_q;
  assign stop  = i_en & scl_filt_q & scl_prev_q & ~sda_prev_q & sda_filt_q;

  // Clearing the lowest set bit leaves something only when several pairs started at once.
  assign multi_start = |(start & (start - {{(NPAIR-1){1'b0}}, 1'b1}));

  always_comb begin
    first_idx = '0;
    for (int k = NPAIR - 1; k >= 0; k--) begin
      if (start[k]) first_idx = 3'(k);
    end
  end

  assign act = (scl_filt_q[sel_q] ^ scl_prev_q[sel_q]) | (sda_filt_q[sel_q] ^ sda_prev_q[sel_q]);
  assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + TO_W'(1);
  assign timeout_hit = (i_to_lim != '0) && (cnt_inc >= i_to_lim);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    conflict_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|start) begin
          state_d    = S_LOCK;
          sel_d      = first_idx;
          conflict_d = multi_start;
        end
      end
      S_LOCK: begin
        if (!i_en[sel_q]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (stop[sel_q]) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (act) begin
          cnt_d = '0;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HOLD: begin
        if (!i_en[sel_q]) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (start[sel_q]) begin
          state_d = S_LOCK;
          cnt_d   = '0;
        end else if ((i_to_lim == '0) || timeout_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so a fresh lock shows the START edge immediately.
  always_comb begin
    locked_d  = (state_d != S_IDLE);
    scl_out_d = locked_d ? scl_filt_q[sel_d] : 1'b1;
    sda_out_d = locked_d ? sda_filt_q[sel_d] : 1'b1;
    oe_d      = '0;
    if ((state_d == S_LOCK) && i_slv_sda_oe) oe_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      scl_out_q  <= 1'b1;
      sda_out_q  <= 1'b1;
      oe_q       <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      scl_out_q  <= scl_out_d;
      sda_out_q  <= sda_out_d;
      oe_q       <= oe_d;
    end
  end

  assign o_scl      = scl_out_q;
  assign o_sda      = sda_out_q;
  assign o_sda_oe   = oe_q;
  assign o_sel      = sel_q;
  assign o_lock     = (state_q != S_IDLE);
  assign o_conflict = conflict_q;

endmodule

// File: tb/tb_dbgi2c_port_arb.sv
// Bench for dbgi2c_port_arb: a cycle reference model built from pin history plus
// hand-written I2C sequences, a glitch table and a randomized soak.
module tb_dbgi2c_port_arb;
  localparam int NPAIR = 5;
  localparam int TO_W  = 16;

  logic             clk = 1'b0;
  logic             rstz;
  logic [NPAIR-1:0] i_en, i_scl, i_sda;
  logic             i_slv_sda_oe;
  logic [TO_W-1:0]  i_to_lim;
  logic             o_scl, o_sda, o_lock, o_conflict;
  logic [NPAIR-1:0] o_sda_oe;
  logic [2:0]       o_sel;

  always #5 clk = ~clk;

  dbgi2c_port_arb #(.NPAIR(NPAIR), .TO_W(TO_W)) dut (
    .clk(clk), .rstz(rstz), .i_en(i_en), .i_scl(i_scl), .i_sda(i_sda),
    .i_slv_sda_oe(i_slv_sda_oe), .i_to_lim(i_to_lim), .o_scl(o_scl), .o_sda(o_sda),
    .o_sda_oe(o_sda_oe), .o_sel(o_sel), .o_lock(o_lock), .o_conflict(o_conflict)
  );

  logic [NPAIR-1:0] dEn, dScl, dSda;
  logic             dOe;
  logic [TO_W-1:0]  dLim;

  logic [NPAIR-1:0] hScl [7];
  logic [NPAIR-1:0] hSda [7];
  int               mState, mSel, mCnt;
  logic             eScl, eSda, eLock, eConf;
  logic [NPAIR-1:0] eOe;
  logic [2:0]       eSel;

  int nChecks = 0;
  int nFail = 0;
  int confSeen = 0;

  typedef struct {
    int         pair;
    int         lowLen;
    logic       expLock;
    logic [2:0] expSel;
  } glitchVec_t;
  glitchVec_t gv [5];
  logic [7:0] byteVal;

  function automatic logic [NPAIR-1:0] maj3(input logic [NPAIR-1:0] a, input logic [NPAIR-1:0] b,
                                             input logic [NPAIR-1:0] c);
    logic [NPAIR-1:0] r;
    for (int k = 0; k < NPAIR; k++) r[k] = ((int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2);
    return r;
  endfunction

  task automatic modelReset();
    for (int j = 0; j < 7; j++) begin
      hScl[j] = '1;
      hSda[j] = '1;
    end
    mState = 0; mSel = 0; mCnt = 0;
    eScl = 1'b1; eSda = 1'b1; eOe = '0; eSel = '0; eLock = 1'b0; eConf = 1'b0;
  endtask

  // Filtered level after a clock edge is the majority of the pins seen 3..5 cycles earlier.
  task automatic modelStep();
    logic [NPAIR-1:0] fScl, pScl, fSda, pSda, st, sp;
    int nStart, lim;
    logic act;
    for (int j = 6; j > 0; j--) begin
      hScl[j] = hScl[j-1];
      hSda[j] = hSda[j-1];
    end
    hScl[0] = dScl;
    hSda[0] = dSda;
    fScl = maj3(hScl[3], hScl[4], hScl[5]);
    pScl = maj3(hScl[4], hScl[5], hScl[6]);
    fSda = maj3(hSda[3], hSda[4], hSda[5]);
    pSda = maj3(hSda[4], hSda[5], hSda[6]);
    nStart = 0;
    for (int k = 0; k < NPAIR; k++) begin
      st[k] = dEn[k] && fScl[k] && pScl[k] && pSda[k] && !fSda[k];
      sp[k] = dEn[k] && fScl[k] && pScl[k] && !pSda[k] && fSda[k];
      nStart += int'(st[k]);
    end
    act = (fScl[mSel] != pScl[mSel]) || (fSda[mSel] != pSda[mSel]);
    lim = int'(dLim);
    eConf = 1'b0;
    if (mState == 0) begin
      mCnt = 0;
      if (nStart > 0) begin
        for (int k = NPAIR - 1; k >= 0; k--) if (st[k]) mSel = k;
        mState = 1;
        eConf = (nStart > 1);
      end
    end else if (!dEn[mSel]) begin
      mState = 0; mCnt = 0;
    end else if (mState == 1) begin
      if (sp[mSel]) begin
        mState = 2; mCnt = 0;
      end else if (act) begin
        mCnt = 0;
      end else begin
        mCnt = (mCnt < 65535) ? mCnt + 1 : mCnt;
        if (lim != 0 && mCnt >= lim) begin mState = 0; mCnt = 0; end
      end
    end else begin
      if (st[mSel]) begin
        mState = 1; mCnt = 0;
      end else if (lim == 0) begin
        mState = 0; mCnt = 0;
      end else begin
        mCnt = (mCnt < 65535) ? mCnt + 1 : mCnt;
        if (mCnt >= lim) begin mState = 0; mCnt = 0; end
      end
    end
    eLock = (mState != 0);
    eSel  = 3'(mSel);
    eScl  = eLock ? fScl[mSel] : 1'b1;
    eSda  = eLock ? fSda[mSel] : 1'b1;
    eOe   = '0;
    if (mState == 1 && dOe) eOe[mSel] = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("o_scl", 32'(o_scl), 32'(eScl));
    cmp("o_sda", 32'(o_sda), 32'(eSda));
    cmp("o_sda_oe", 32'(o_sda_oe), 32'(eOe));
    cmp("o_sel", 32'(o_sel), 32'(eSel));
    cmp("o_lock", 32'(o_lock), 32'(eLock));
    cmp("o_conflict", 32'(o_conflict), 32'(eConf));
    if (o_conflict === 1'b1) confSeen++;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      i_en = dEn; i_scl = dScl; i_sda = dSda; i_slv_sda_oe = dOe; i_to_lim = dLim;
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  initial begin
    gv[0] = '{pair: 0, lowLen: 1, expLock: 1'b0, expSel: 3'd0};
    gv[1] = '{pair: 0, lowLen: 3, expLock: 1'b1, expSel: 3'd0};
    gv[2] = '{pair: 2, lowLen: 1, expLock: 1'b0, expSel: 3'd0};
    gv[3] = '{pair: 2, lowLen: 4, expLock: 1'b1, expSel: 3'd2};
    gv[4] = '{pair: 4, lowLen: 3, expLock: 1'b1, expSel: 3'd4};

    rstz = 1'b0;
    dEn = '1; dScl = '1; dSda = '1; dOe = 1'b0; dLim = 16'd1000;
    i_en = dEn; i_scl = dScl; i_sda = dSda; i_slv_sda_oe = dOe; i_to_lim = dLim;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    rstz = 1'b1;

    // Idle bus after reset.
    confSeen = 0;
    applyStimulus(100);
    cmp("idle_lock", 32'(o_lock), 32'd0);
    cmp("idle_scl", 32'(o_scl), 32'd1);
    cmp("idle_sda", 32'(o_sda), 32'd1);
    cmp("idle_conflict_count", 32'(confSeen), 32'd0);

    // Write to 0x52 on pair 3 with ACK, STOP, then the 1000-cycle hold.
    dSda[3] = 1'b0;
    applyStimulus(5);
    cmp("wr_lock", 32'(o_lock), 32'd1);
    cmp("wr_sel", 32'(o_sel), 32'd3);
    cmp("wr_start_sda", 32'(o_sda), 32'd0);
    cmp("wr_start_scl", 32'(o_scl), 32'd1);
    dScl[3] = 1'b0;
    applyStimulus(2);
    byteVal = 8'hA4;
    for (int b = 7; b >= 0; b--) begin
      dSda[3] = byteVal[b];
      applyStimulus(2);
      dScl[3] = 1'b1;
      applyStimulus(4);
      dScl[3] = 1'b0;
      applyStimulus(2);
    end
    dSda[3] = 1'b1;
    dOe = 1'b1;
    applyStimulus(2);
    cmp("wr_ack_oe", 32'(o_sda_oe), 32'h08);
    dScl[3] = 1'b1;
    applyStimulus(4);
    dScl[3] = 1'b0;
    applyStimulus(1);
    dOe = 1'b0;
    dSda[3] = 1'b0;
    applyStimulus(2);
    dScl[3] = 1'b1;
    applyStimulus(4);
    dSda[3] = 1'b1;
    applyStimulus(20);
    cmp("wr_hold_lock", 32'(o_lock), 32'd1);
    applyStimulus(990);
    cmp("wr_release_lock", 32'(o_lock), 32'd0);
    cmp("wr_release_sel", 32'(o_sel), 32'd3);

    // Simultaneous START on pairs 1 and 4.
    dLim = 16'd40;
    confSeen = 0;
    dSda[1] = 1'b0;
    dSda[4] = 1'b0;
    applyStimulus(6);
    cmp("conf_sel", 32'(o_sel), 32'd1);
    cmp("conf_lock", 32'(o_lock), 32'd1);
    dOe = 1'b1;
    repeat (3) begin
      dScl[4] = 1'b0;
      applyStimulus(2);
      dScl[4] = 1'b1;
      applyStimulus(2);
    end
    cmp("conf_oe", 32'(o_sda_oe), 32'h02);
    dOe = 1'b0;
    applyStimulus(60);
    cmp("conf_pulses", 32'(confSeen), 32'd1);
    cmp("conf_timeout_lock", 32'(o_lock), 32'd0);
    dScl = '1;
    dSda = '1;
    applyStimulus(10);

    // Glitch rejection table.
    dLim = 16'd8;
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < 8; c++) begin
        dSda[gv[v].pair] = (c < gv[v].lowLen) ? 1'b0 : 1'b1;
        applyStimulus(1);
      end
      cmp("glitch_lock", 32'(o_lock), 32'(gv[v].expLock));
      if (gv[v].expLock) cmp("glitch_sel", 32'(o_sel), 32'(gv[v].expSel));
      applyStimulus(30);
      cmp("glitch_release", 32'(o_lock), 32'd0);
    end

    // Stuck SCL on pair 2, first with a 16-cycle limit, then with timeout disabled.
    dLim = 16'd16;
    dSda[2] = 1'b0;
    applyStimulus(6);
    dScl[2] = 1'b0;
    applyStimulus(10);
    cmp("stuck_lock", 32'(o_lock), 32'd1);
    cmp("stuck_sel", 32'(o_sel), 32'd2);
    applyStimulus(30);
    cmp("stuck_timeout", 32'(o_lock), 32'd0);
    dScl[2] = 1'b1;
    applyStimulus(4);
    dSda[2] = 1'b1;
    applyStimulus(10);
    dLim = 16'd0;
    dSda[2] = 1'b0;
    applyStimulus(6);
    dScl[2] = 1'b0;
    applyStimulus(200);
    cmp("stuck_nolimit", 32'(o_lock), 32'd1);
    dEn[2] = 1'b0;
    applyStimulus(1);
    cmp("stuck_disable", 32'(o_lock), 32'd0);
    dScl[2] = 1'b1;
    dSda[2] = 1'b1;
    applyStimulus(6);
    dEn = '1;
    applyStimulus(2);

    // Enable dropped mid-byte on pair 0.
    dLim = 16'd100;
    dSda[0] = 1'b0;
    applyStimulus(6);
    cmp("en_sel", 32'(o_sel), 32'd0);
    dScl[0] = 1'b0;
    applyStimulus(2);
    dOe = 1'b1;
    dSda[0] = 1'b1;
    applyStimulus(2);
    cmp("en_oe_before", 32'(o_sda_oe), 32'h01);
    dScl[0] = 1'b1;
    applyStimulus(2);
    dEn[0] = 1'b0;
    applyStimulus(1);
    cmp("en_lock", 32'(o_lock), 32'd0);
    cmp("en_oe", 32'(o_sda_oe), 32'd0);
    dOe = 1'b0;
    dEn[0] = 1'b1;
    applyStimulus(4);

    // Asynchronous reset in the middle of a pair-1 transaction.
    dSda[1] = 1'b0;
    applyStimulus(6);
    dScl[1] = 1'b0;
    dOe = 1'b1;
    applyStimulus(3);
    cmp("rst_pre_oe", 32'(o_sda_oe), 32'h02);
    #2;
    rstz = 1'b0;
    #1;
    cmp("arst_scl", 32'(o_scl), 32'd1);
    cmp("arst_sda", 32'(o_sda), 32'd1);
    cmp("arst_oe", 32'(o_sda_oe), 32'd0);
    cmp("arst_sel", 32'(o_sel), 32'd0);
    cmp("arst_lock", 32'(o_lock), 32'd0);
    cmp("arst_conflict", 32'(o_conflict), 32'd0);
    dScl = '1; dSda = '1; dOe = 1'b0;
    i_scl = dScl; i_sda = dSda; i_slv_sda_oe = dOe;
    repeat (2) @(posedge clk);
    #1;
    rstz = 1'b1;
    modelReset();

    // Randomized soak against the reference model.
    dEn = '1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) dLim = 16'($urandom_range(0, 30));
      for (int k = 0; k < NPAIR; k++) begin
        if ($urandom_range(0, 7) == 0) dScl[k] = ~dScl[k];
        if ($urandom_range(0, 7) == 0) dSda[k] = ~dSda[k];
        if ($urandom_range(0, 199) == 0) dEn[k] = ~dEn[k];
      end
      dOe = ($urandom_range(0, 2) == 0);
      applyStimulus(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/dbgi2c_port_arb.md
# dbgi2c_port_arb

Debug-I2C port arbiter. It sits between the chip's candidate I2C pin pairs and the single internal I2C slave. The pairs are SCL/SDA, CC2/CC1, CC1/CC2 (swapped), DN/DP and DP/DN (swapped). The arbiter watches every enabled pair for an I2C START and locks the slave onto the first pair that shows one. It routes that pair's filtered SCL/SDA to the slave and steers the slave's SDA pull-down back onto that pair only. It releases the lock after STOP plus an idle hold, or after a stuck-bus timeout.

## Interface
- NPAIR, 5: number of candidate pin pairs; index order is fixed as listed above (0..4).
- TO_W, 16: width of the idle-timeout counter.
- clk  in  1  system clock (CCLK domain).
- rstz  in  1  asynchronous, active-low reset.
- i_en  in  NPAIR  per-pair enable, from register bits; 0 = pair ignored.
- i_scl  in  NPAIR  raw SCL pin level per pair (already swapped per pair); asynchronous.
- i_sda  in  NPAIR  raw SDA pin level per pair; asynchronous.
- i_slv_sda_oe  in  1  internal slave requests SDA driven low.
- i_to_lim  in  TO_W  idle-timeout limit in clk cycles; 0 = timeout disabled.
- o_scl  out  1  SCL to internal slave.
- o_sda  out  1  SDA to internal slave.
- o_sda_oe  out  NPAIR  per-pair SDA drive-low enable.
- o_sel  out  3  index of the locked or last-locked pair.
- o_lock  out  1  1 in LOCK or HOLD.
- o_conflict  out  1  one-cycle pulse when START is seen on more than one pair in the same cycle.

## Operation
- Every i_scl/i_sda bit passes through a 2-flop synchronizer, then a 3-sample majority filter with a registered output (filt). Each pulse of 1 clk or less is rejected.
- Synchronizer and filter flops reset to 1 (bus idle), so no edge appears after reset.
- Per-pair START detection: en[k] & filt_scl[k] & filt_scl_d[k] & filt_sda_d[k] & ~filt_sda[k].
- STOP detection is the same expression with SDA rising.
- "Activity" on the selected pair means any edge on its filt_scl or filt_sda.
- States:
  - IDLE: o_lock=0. On any START, sel <= lowest index k with START, then go to LOCK. If more than one pair has START, pulse o_conflict.
  - LOCK: track the selected pair.
    - STOP → HOLD, counter cleared.
    - No activity for i_to_lim consecutive cycles (i_to_lim≠0) → IDLE (stuck bus).
    - Each activity cycle clears the counter.
  - HOLD: bus idle after STOP.
    - START on the selected pair → LOCK, counter cleared.
    - Counter reaches i_to_lim → IDLE.
    - If i_to_lim=0, go to IDLE on the next cycle.
    - STARTs on other pairs are ignored.
- In LOCK or HOLD, STARTs on non-selected pairs are ignored and produce no o_conflict.
- If i_en[sel] falls while in LOCK or HOLD, go to IDLE next cycle; outputs are released that same cycle.
- Timeout counter: TO_W bits, saturating, cleared in IDLE.
- o_scl/o_sda (registered):
  - in LOCK/HOLD: filt_scl[sel]/filt_sda[sel];
  - otherwise: 1/1.
- o_sda_oe[k] (registered): (state==LOCK) & (k==sel) & i_slv_sda_oe. It is never asserted in IDLE or HOLD, and at most one bit is ever set.
- o_sel holds its value through IDLE until the next lock.
- Clock stretching is not supported; SCL is never driven.

## Timing
- Reset values: o_scl=1, o_sda=1, o_sda_oe=0, o_sel=0, o_lock=0, o_conflict=0, state=IDLE, counter=0.
- Pin edge → filt: 4 clk. filt → o_scl/o_sda: 1 clk. Total pin → slave: 5 clk.
- START at filt in cycle N:
  - state=LOCK and o_lock=1 at N+1;
  - o_sda first shows 0 at N+1 while o_scl=1, so the slave sees a clean START.
- i_slv_sda_oe → o_sda_oe: 1 clk.
- Timeout with limit L: IDLE is entered on the cycle after L consecutive inactive cycles.
- Leaving LOCK/HOLD for any reason: o_lock=0, o_sda_oe=0, o_scl=o_sda=1 in the first IDLE cycle.
- Reset asserted mid-transaction: all outputs take their reset values asynchronously.

## Test plan
- Reset, all i_scl/i_sda=1, i_en=5'h1F, 100 clk → o_lock=0, o_scl=o_sda=1, o_conflict never asserted.
- I2C write to address 0x52 on pair 3 (DN/DP), i_to_lim=1000 → o_sel=3, o_lock=1 within 5 clk of the SDA fall. o_scl/o_sda track pair 3 delayed 5 clk. ACK from i_slv_sda_oe appears only on o_sda_oe[3]. HOLD is entered after STOP, then IDLE 1000 clk later.
- Simultaneous START on pairs 1 and 4 → o_sel=1 and o_conflict pulses exactly 1 clk. The pair-4 transaction is ignored and o_sda_oe[4] stays 0.
- 1-clk SDA low glitch on pair 0 with SCL high → no lock. A 3-clk-wide low → lock.
- Lock on pair 2, hold SCL low, i_to_lim=16 → IDLE after 16 inactive cycles. With i_to_lim=0 and the same stimulus → stays in LOCK indefinitely.
- Lock on pair 0, then clear i_en[0] mid-byte → IDLE next clk, o_sda_oe=0. Assert rstz=0 mid-transaction → all outputs at reset values immediately.
